// File: rtl/cdc_toggle_tx.sv
// Source end of a two-phase toggle handshake: holds a word stable and flips req,
// then waits for the remote ack toggle (synchronised here) before taking another word.
module cdc_toggle_tx #(
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          SyncStages     = 2,
  parameter logic [DataWidth-1:0] DataResetValue = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 async_req_o,
  output logic [DataWidth-1:0] async_data_o,
  input  logic                 async_ack_i,
  output logic                 err_o
);

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic                    err_q, err_d;
  logic [SyncStages-1:0]   ack_sync_q, ack_sync_d;
  logic                    ack_s;

  assign ack_s = ack_sync_q[SyncStages-1];

  // ready is built from registers only, so the asynchronous ack never reaches an output.
  assign ready_o      = (state_q == IDLE) && (ack_s == req_q) && !err_q;
  assign async_req_o  = req_q;
  assign async_data_o = data_q;
  assign err_o        = err_q;

  always_comb begin
    ack_sync_d = {ack_sync_q[SyncStages-2:0], async_ack_i};
    state_d    = state_q;
    req_d      = req_q;
    data_d     = data_q;
    err_d      = err_q;

    if (clr_i) begin
      ack_sync_d = '0;
      state_d    = IDLE;
      req_d      = 1'b0;
      data_d     = DataResetValue;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // An ack edge while nothing is outstanding means the two sides lost phase.
          if (ack_s != req_q) begin
            err_d = 1'b1;
          end else if (valid_i && ready_o) begin
            data_d  = data_i;
            req_d   = ~req_q;
            state_d = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_s == req_q) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_sync_q <= '0;
      state_q    <= IDLE;
      req_q      <= 1'b0;
      data_q     <= DataResetValue;
      err_q      <= 1'b0;
    end else begin
      ack_sync_q <= ack_sync_d;
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_cdc_toggle_tx.sv
// Directed bench for cdc_toggle_tx: reset, loopback transfers, stalled ack,
// idle-ack error, clear mid-transfer and a back-to-back ordered stream.
module tb_cdc_toggle_tx;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clr_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_i = '0;
  logic        async_req_o;
  logic [31:0] async_data_o;
  logic        async_ack_i;
  logic        err_o;

  logic        loopback = 1'b0;
  logic        ack_man = 1'b0;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic        mon_en = 1'b0;
  logic        mon_req = 1'b0;
  logic [31:0] mon_data = '0;
  logic [31:0] seen_q[$];
  logic [31:0] words[16];

  assign async_ack_i = loopback ? async_req_o : ack_man;

  always #5 clk_i = ~clk_i;

  cdc_toggle_tx #(
    .DataWidth(32),
    .SyncStages(2),
    .DataResetValue(32'h0)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .clr_i(clr_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i(data_i),
    .async_req_o(async_req_o),
    .async_data_o(async_data_o),
    .async_ack_i(async_ack_i),
    .err_o(err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Records every word launched with a req toggle; data must not move otherwise.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (async_req_o != mon_req) seen_q.push_back(async_data_o);
      else check_eq("data_stable", async_data_o, mon_data);
    end
    mon_req  = async_req_o;
    mon_data = async_data_o;
  end

  initial begin
    int n;

    // 1: reset values
    tick();
    check_eq("rst_req", 32'(async_req_o), 32'd0);
    check_eq("rst_data", async_data_o, 32'h0);
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    check_eq("rst_err", 32'(err_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // 2: loopback single transfers
    loopback = 1'b1;
    tick();
    valid_i = 1'b1;
    data_i  = 32'hA5A50001;
    tick();
    valid_i = 1'b0;
    check_eq("lb1_req", 32'(async_req_o), 32'd1);
    check_eq("lb1_data", async_data_o, 32'hA5A50001);
    check_eq("lb1_rdy0", 32'(ready_o), 32'd0);
    tick();
    check_eq("lb1_rdy1", 32'(ready_o), 32'd0);
    tick();
    check_eq("lb1_rdy2", 32'(ready_o), 32'd0);
    tick();
    check_eq("lb1_rdy3", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    data_i  = 32'h0000BEEF;
    tick();
    valid_i = 1'b0;
    check_eq("lb2_req", 32'(async_req_o), 32'd0);
    check_eq("lb2_data", async_data_o, 32'h0000BEEF);
    tick();
    tick();
    tick();
    check_eq("lb2_rdy", 32'(ready_o), 32'd1);
    check_eq("lb2_err", 32'(err_o), 32'd0);

    // 3: ack held low, word must stay put while data_i churns
    ack_man  = 1'b0;
    loopback = 1'b0;
    tick();
    valid_i = 1'b1;
    data_i  = 32'h12345678;
    tick();
    check_eq("st_req", 32'(async_req_o), 32'd1);
    for (int i = 0; i < 100; i++) begin
      data_i = $urandom;
      tick();
      check_eq("st_ready", 32'(ready_o), 32'd0);
      check_eq("st_data", async_data_o, 32'h12345678);
      check_eq("st_req_hold", 32'(async_req_o), 32'd1);
    end
    valid_i = 1'b0;
    ack_man = 1'b1;
    tick();
    tick();
    tick();
    check_eq("st_release_rdy", 32'(ready_o), 32'd1);
    check_eq("st_release_err", 32'(err_o), 32'd0);

    // 5: clear while waiting for ack, with a word offered
    valid_i = 1'b1;
    data_i  = 32'hCAFE0005;
    tick();
    check_eq("clr_pre_req", 32'(async_req_o), 32'd0);
    check_eq("clr_pre_data", async_data_o, 32'hCAFE0005);
    check_eq("clr_pre_rdy", 32'(ready_o), 32'd0);
    clr_i   = 1'b1;
    ack_man = 1'b0;
    data_i  = 32'hDEAD0006;
    tick();
    clr_i   = 1'b0;
    valid_i = 1'b0;
    check_eq("clr_req", 32'(async_req_o), 32'd0);
    check_eq("clr_data", async_data_o, 32'h0);
    check_eq("clr_rdy", 32'(ready_o), 32'd1);
    tick();
    tick();
    check_eq("clr_noacc_req", 32'(async_req_o), 32'd0);
    check_eq("clr_noacc_data", async_data_o, 32'h0);
    check_eq("clr_noacc_err", 32'(err_o), 32'd0);

    // 4: ack toggles while idle -> sticky error
    ack_man = 1'b1;
    tick();
    tick();
    check_eq("err_early", 32'(err_o), 32'd0);
    tick();
    check_eq("err_set", 32'(err_o), 32'd1);
    check_eq("err_rdy", 32'(ready_o), 32'd0);
    ack_man = 1'b0;
    tick();
    tick();
    tick();
    check_eq("err_sticky", 32'(err_o), 32'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check_eq("err_clr", 32'(err_o), 32'd0);
    check_eq("err_clr_rdy", 32'(ready_o), 32'd1);
    tick();
    tick();
    check_eq("err_clr_hold", 32'(err_o), 32'd0);

    // 6: loopback stream of 16 words, valid held
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    loopback = 1'b1;
    tick();
    mon_en  = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_i = words[i];
      n = 0;
      while (!ready_o && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) check_eq("stream_timeout", 32'(n), 32'd0);
      tick();
    end
    valid_i = 1'b0;
    repeat (6) tick();
    mon_en = 1'b0;
    check_eq("stream_count", 32'(seen_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < seen_q.size()) check_eq("stream_word", seen_q[i], words[i]);
    end
    check_eq("stream_err", 32'(err_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
